// File: rtl/bos_power_seq.sv
// bos_power_seq: command-driven BOS supply/reset sequencer on the message bus.
// Build option `BOS_PWR_MONITOR_EN: power-good loss while ON forces a faulted power-down.
module bos_power_seq #(
    parameter int STEP_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 20
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] master_data,
    input  logic       ena,
    input  logic       rdreq,
    output logic       have_msg,
    output logic [7:0] data_out,
    output logic [7:0] len,
    input  logic       sbis_power_on,
    output logic       off_vcore_fpga,
    output logic       off_vdigital_fpga,
    output logic       functional,
    output logic       off_pr_digital_fpga,
    output logic       rst_fpga,
    output logic       stby_fpga
);

    localparam logic [3:0] S_OFF     = 4'h0;
    localparam logic [3:0] S_U_VCORE = 4'h1;
    localparam logic [3:0] S_U_VDIG  = 4'h2;
    localparam logic [3:0] S_U_FUNC  = 4'h3;
    localparam logic [3:0] S_U_PR    = 4'h4;
    localparam logic [3:0] S_U_RST   = 4'h5;
    localparam logic [3:0] S_WAIT_OK = 4'h6;
    localparam logic [3:0] S_ON      = 4'h7;
    localparam logic [3:0] S_D_RST   = 4'h8;
    localparam logic [3:0] S_D_FUNC  = 4'h9;
    localparam logic [3:0] S_D_VDIG  = 4'hA;
    localparam logic [3:0] S_D_VCORE = 4'hB;

    localparam logic [7:0] CMD_DOWN     = 8'h00;
    localparam logic [7:0] CMD_UP       = 8'h01;
    localparam logic [7:0] CMD_STATUS   = 8'h02;
    localparam logic [7:0] CMD_STBY_OFF = 8'h10;
    localparam logic [7:0] CMD_STBY_ON  = 8'h11;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             fault;
    logic             fault_nxt;
    logic [1:0]       pg_sync;
    logic             pg;
    logic             pg_lost;
    logic             step_done;
    logic             tmo_done;
    logic             powered;
    logic             reply;
    logic [7:0]       reply_byte;
    logic             stby_set;
    logic             stby_clr;
    logic             vcore_n;
    logic             vdig_n;
    logic             func_n;
    logic             pr_n;
    logic             rstf_n;
    logic             stby_n;

    assign len        = 8'd1;
    assign pg         = pg_sync[1];
    assign step_done  = (cnt == STEP_LAST);
    assign tmo_done   = (cnt == TMO_LAST);
    assign powered    = (state >= S_U_VCORE) && (state <= S_ON);
    assign reply_byte = {fault_nxt, 3'b000, state_nxt};

`ifdef BOS_PWR_MONITOR_EN
    logic [3:0] low_cnt;

    // Counts consecutive low cycles of power-good while ON; 16th one trips.
    assign pg_lost = (state == S_ON) && !pg && (low_cnt == 4'hF);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            low_cnt <= 4'h0;
        end else if (state != S_ON || pg) begin
            low_cnt <= 4'h0;
        end else if (low_cnt != 4'hF) begin
            low_cnt <= low_cnt + 4'd1;
        end
    end
`else
    assign pg_lost = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        fault_nxt = fault;
        reply     = 1'b0;
        stby_set  = 1'b0;
        stby_clr  = 1'b0;

        unique case (state)
            S_U_VCORE, S_U_VDIG, S_U_FUNC, S_U_PR, S_U_RST,
            S_D_RST, S_D_FUNC, S_D_VDIG: begin
                if (step_done) state_nxt = state + 4'd1;
            end
            S_WAIT_OK: begin
                if (pg) begin
                    state_nxt = S_ON;
                    reply     = 1'b1;
                end else if (tmo_done) begin
                    state_nxt = S_D_RST;
                    fault_nxt = 1'b1;
                end
            end
            S_ON: begin
                if (pg_lost) begin
                    state_nxt = S_D_RST;
                    fault_nxt = 1'b1;
                    reply     = 1'b1;
                end
            end
            S_D_VCORE: begin
                if (step_done) begin
                    state_nxt = S_OFF;
                    reply     = 1'b1;
                end
            end
            default: ;
        endcase

        // A command overrides any step advance in the same cycle.
        if (ena) begin
            reply = 1'b1;
            unique case (1'b1)
                (master_data == CMD_UP): begin
                    if (state == S_OFF) begin
                        state_nxt = S_U_VCORE;
                        fault_nxt = 1'b0;
                    end
                end
                (master_data == CMD_DOWN): begin
                    if (powered) state_nxt = S_D_RST;
                end
                (master_data == CMD_STBY_ON): begin
                    if (state == S_ON && state_nxt == S_ON) stby_set = 1'b1;
                end
                (master_data == CMD_STBY_OFF): begin
                    if (state == S_ON && state_nxt == S_ON) stby_clr = 1'b1;
                end
                (master_data == CMD_STATUS): ;
                default: ;
            endcase
        end
    end

    always_comb begin
        vcore_n = off_vcore_fpga;
        vdig_n  = off_vdigital_fpga;
        func_n  = functional;
        pr_n    = off_pr_digital_fpga;
        rstf_n  = rst_fpga;
        stby_n  = stby_fpga;

        if (state_nxt != state) begin
            unique case (state_nxt)
                S_U_VCORE: vcore_n = 1'b0;
                S_U_VDIG:  vdig_n  = 1'b0;
                S_U_FUNC:  func_n  = 1'b1;
                S_U_PR:    pr_n    = 1'b0;
                S_U_RST:   rstf_n  = 1'b0;
                S_D_RST: begin
                    rstf_n = 1'b1;
                    stby_n = 1'b0;
                    pr_n   = 1'b1;
                end
                S_D_FUNC:  func_n  = 1'b0;
                S_D_VDIG:  vdig_n  = 1'b1;
                S_D_VCORE: vcore_n = 1'b1;
                default: ;
            endcase
        end

        if (stby_set) begin
            stby_n = 1'b1;
        end else if (stby_clr) begin
            stby_n = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state               <= S_OFF;
            cnt                 <= '0;
            fault               <= 1'b0;
            pg_sync             <= 2'b00;
            off_vcore_fpga      <= 1'b1;
            off_vdigital_fpga   <= 1'b1;
            functional          <= 1'b0;
            off_pr_digital_fpga <= 1'b1;
            rst_fpga            <= 1'b1;
            stby_fpga           <= 1'b0;
            have_msg            <= 1'b0;
            data_out            <= 8'h00;
        end else begin
            state               <= state_nxt;
            fault               <= fault_nxt;
            pg_sync             <= {pg_sync[0], sbis_power_on};
            off_vcore_fpga      <= vcore_n;
            off_vdigital_fpga   <= vdig_n;
            functional          <= func_n;
            off_pr_digital_fpga <= pr_n;
            rst_fpga            <= rstf_n;
            stby_fpga           <= stby_n;

            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state != S_OFF && state != S_ON) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Single-entry reply buffer: newest reply wins over a pending one.
            if (reply) begin
                have_msg <= 1'b1;
                data_out <= reply_byte;
            end else if (rdreq && have_msg) begin
                have_msg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bos_power_seq.sv
// tb_bos_power_seq: randomized scoreboard bench for bos_power_seq.
// Reply bytes are queued at issue time and popped by an independent monitor.
module tb_bos_power_seq;

    localparam int STEP = 4;
    localparam int TMO  = 64;

    localparam logic [5:0] OFF_OUTS = 6'b110110;
    localparam logic [5:0] ON_OUTS  = 6'b001000;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] master_data = 8'h00;
    logic       ena = 1'b0;
    logic       rdreq;
    logic       have_msg;
    logic [7:0] data_out;
    logic [7:0] len;
    logic       sbis_power_on = 1'b0;
    logic       off_vcore_fpga;
    logic       off_vdigital_fpga;
    logic       functional;
    logic       off_pr_digital_fpga;
    logic       rst_fpga;
    logic       stby_fpga;

    logic       mon_en = 1'b1;
    logic       mon_rd = 1'b0;
    logic       man_rdreq = 1'b0;
    logic [5:0] outs;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];

    assign rdreq = mon_en ? mon_rd : man_rdreq;
    assign outs  = {off_vcore_fpga, off_vdigital_fpga, functional,
                    off_pr_digital_fpga, rst_fpga, stby_fpga};

    bos_power_seq #(
        .STEP_CYCLES   (STEP),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (20)
    ) dut (
        .sys_clk            (sys_clk),
        .rst                (rst),
        .master_data        (master_data),
        .ena                (ena),
        .rdreq              (rdreq),
        .have_msg           (have_msg),
        .data_out           (data_out),
        .len                (len),
        .sbis_power_on      (sbis_power_on),
        .off_vcore_fpga     (off_vcore_fpga),
        .off_vdigital_fpga  (off_vdigital_fpga),
        .functional         (functional),
        .off_pr_digital_fpga(off_pr_digital_fpga),
        .rst_fpga           (rst_fpga),
        .stby_fpga          (stby_fpga)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Levels r edges after UP was accepted, while still powering up.
    function automatic logic [5:0] up_outs(input int r);
        return {1'b0, !(r >= STEP), (r >= 2*STEP), !(r >= 3*STEP),
                !(r >= 4*STEP), 1'b0};
    endfunction

    function automatic int up_code(input int r);
        return (r < 5*STEP) ? 1 + r/STEP : 6;
    endfunction

    // Levels r edges after D_RST entry, starting from the levels before it.
    function automatic logic [5:0] down_outs(input logic [5:0] prior, input int r);
        logic [5:0] o;
        o = prior;
        o[2] = 1'b1;
        o[1] = 1'b1;
        o[0] = 1'b0;
        if (r >= STEP)   o[3] = 1'b0;
        if (r >= 2*STEP) o[4] = 1'b1;
        if (r >= 3*STEP) o[5] = 1'b1;
        return o;
    endfunction

    always @(negedge sys_clk) begin
        mon_rd = 1'b0;
        if (mon_en && have_msg === 1'b1) begin
            mon_rd = 1'b1;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_reply: got 0x%0h, expected none (cycle %0d)",
                         data_out, cyc);
            end else begin
                check("reply", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b, output int at);
        master_data = b;
        ena = 1'b1;
        @(negedge sys_clk);
        ena = 1'b0;
        master_data = 8'h00;
        at = cyc;
    endtask

    task automatic cmd(input logic [7:0] b, input logic [7:0] exp_reply);
        int t;
        exp_q.push_back(exp_reply);
        send(b, t);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t - 1) @(negedge sys_clk);
    endtask

    task automatic run_down(input logic [5:0] prior, input int dn_at,
                            input logic [7:0] fin);
        while (cyc - dn_at <= 4*STEP) begin
            check("down_outs", {26'h0, outs}, {26'h0, down_outs(prior, cyc - dn_at)});
            if (cyc - dn_at == 4*STEP - 1) exp_q.push_back(fin);
            @(negedge sys_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int up_at;
        int dn_at;
        int s;
        int d;
        int c0;
        bit seen;

        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset_outs", {26'h0, outs}, {26'h0, OFF_OUTS});
        check("reset_have_msg", {31'h0, have_msg}, 32'h0);
        check("reset_data_out", {24'h0, data_out}, 32'h0);
        check("len", {24'h0, len}, 32'h1);
        rst = 1'b0;
        @(negedge sys_clk);
        check("off_outs", {26'h0, outs}, {26'h0, OFF_OUTS});

        // Commands in OFF: only replies, no state change
        cmd(8'h02, 8'h00);
        cmd(8'h00, 8'h00);
        cmd(8'h11, 8'h00);
        cmd(8'h5A, 8'h00);
        check("off_ignore", {26'h0, outs}, {26'h0, OFF_OUTS});

        // Power-up with power-good present
        sbis_power_on = 1'b1;
        repeat (4) @(negedge sys_clk);
        exp_q.push_back(8'h01);
        send(8'h01, up_at);
        s = $urandom_range(1, 18);
        while (cyc - up_at < 5*STEP) begin
            check("up_outs", {26'h0, outs}, {26'h0, up_outs(cyc - up_at)});
            if (cyc - up_at == s - 1) cmd(8'h02, 8'(up_code(s)));
            else @(negedge sys_clk);
        end
        check("wait_ok_outs", {26'h0, outs}, {26'h0, ON_OUTS});
        exp_q.push_back(8'h07);
        @(negedge sys_clk);
        check("on_outs", {26'h0, outs}, {26'h0, ON_OUTS});
        cmd(8'h01, 8'h07);
        cmd(8'h11, 8'h07);
        check("stby_on", {31'h0, stby_fpga}, 32'h1);
        repeat ($urandom_range(1, 6)) @(negedge sys_clk);
        exp_q.push_back(8'h08);
        send(8'h00, dn_at);
        run_down(ON_OUTS | 6'b000001, dn_at, 8'h00);

        // Power-good never arrives: timeout then faulted power-down
        sbis_power_on = 1'b0;
        repeat (4) @(negedge sys_clk);
        exp_q.push_back(8'h01);
        send(8'h01, up_at);
        wait_to(up_at + 5*STEP + TMO);
        check("pre_timeout", {26'h0, outs}, {26'h0, ON_OUTS});
        @(negedge sys_clk);
        run_down(ON_OUTS, up_at + 5*STEP + TMO, 8'h80);
        check("timeout_off", {26'h0, outs}, {26'h0, OFF_OUTS});
        cmd(8'h02, 8'h80);

        // DOWN at random points of the ramp-up; first trial is fixed in U_FUNC
        for (int k = 0; k < 5; k++) begin
            sbis_power_on = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 5)) @(negedge sys_clk);
            exp_q.push_back(8'h01);
            send(8'h01, up_at);
            if (k == 0) begin
                s = 9;
                d = 10;
            end else begin
                s = $urandom_range(1, 15);
                d = $urandom_range(s + 1, 19);
            end
            wait_to(up_at + s);
            cmd(8'h02, 8'(up_code(s)));
            wait_to(up_at + d);
            exp_q.push_back(8'h08);
            send(8'h00, dn_at);
            run_down(up_outs(d - 1), dn_at, 8'h00);
        end

        // Reply buffer handled by hand
        sbis_power_on = 1'b1;
        repeat (6) @(negedge sys_clk);
        mon_en = 1'b0;
        send(8'h01, up_at);
        check("buf_first", {23'h0, have_msg, data_out}, 32'h101);
        wait_to(up_at + 5);
        send(8'h02, t);
        wait_to(up_at + 9);
        send(8'h02, t);
        check("buf_latest", {23'h0, have_msg, data_out}, 32'h103);
        wait_to(up_at + 13);
        man_rdreq = 1'b1;
        send(8'h02, t);
        check("buf_rd_and_new", {23'h0, have_msg, data_out}, 32'h104);
        @(negedge sys_clk);
        check("buf_popped", {31'h0, have_msg}, 32'h0);
        @(negedge sys_clk);
        check("buf_rd_empty", {31'h0, have_msg}, 32'h0);
        man_rdreq = 1'b0;
        mon_en = 1'b1;
        wait_to(up_at + 5*STEP + 1);
        exp_q.push_back(8'h07);
        @(negedge sys_clk);
        cmd(8'h11, 8'h07);
        cmd(8'h10, 8'h07);
        check("stby_off", {31'h0, stby_fpga}, 32'h0);

`ifdef BOS_PWR_MONITOR_EN
        // Short power-good dropout is tolerated, long one forces shutdown
        sbis_power_on = 1'b0;
        repeat (10) @(negedge sys_clk);
        sbis_power_on = 1'b1;
        repeat (6) @(negedge sys_clk);
        cmd(8'h02, 8'h07);
        check("glitch_ignored", {26'h0, outs}, {26'h0, ON_OUTS});
        exp_q.push_back(8'h88);
        sbis_power_on = 1'b0;
        c0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge sys_clk);
            if (rst_fpga === 1'b1) seen = 1'b1;
        end
        check("pg_loss_seen", {31'h0, seen}, 32'h1);
        check("pg_loss_late", {31'h0, (cyc - c0 >= 16)}, 32'h1);
        dn_at = cyc;
        run_down(ON_OUTS, dn_at, 8'h80);
        sbis_power_on = 1'b1;
`else
        c0 = 0;
        seen = 1'b0;
        sbis_power_on = 1'b0;
        repeat (25) @(negedge sys_clk);
        cmd(8'h02, 8'h07);
        check("pg_ignored_on", {26'h0, outs}, {26'h0, ON_OUTS});
        sbis_power_on = 1'b1;
        exp_q.push_back(8'h08);
        send(8'h00, dn_at);
        run_down(ON_OUTS, dn_at, 8'h00);
`endif
        check("final_off", {26'h0, outs}, {26'h0, OFF_OUTS});

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
